// File: rtl/regfile_dump_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_dump_ctrl_pkg
// Brief    : Shared FSM state encoding and helpers for the register-file dumper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_dump_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Index 0 is the hard-wired zero register when skipping is enabled.
   function automatic int unsigned first_index(input int unsigned skip_zero);
      return (skip_zero != 0) ? 32'd1 : 32'd0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
//------------------------------------------------------------------------------
// Module   : regfile_dump_ctrl
// Brief    : Walks the CPU register debug port and streams each value out as a
//            valid/ready beat (index, data, last), with abort and done handling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_dump_ctrl
   import regfile_dump_ctrl_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int SEL_W     = 5,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 1,
   parameter int SKIP_ZERO = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   output logic [SEL_W-1:0]  reg_sel,
   input  logic [DATA_W-1:0] reg_data,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic [SEL_W-1:0]  dout_idx,
   output logic              dout_last,
   output logic              busy,
   output logic              done
);

   localparam int                LAT_W        = $clog2(READ_LAT + 1);
   localparam logic [SEL_W-1:0]  c_first      = SEL_W'(first_index(SKIP_ZERO));
   localparam logic [SEL_W-1:0]  c_last       = SEL_W'(NUM_REGS - 1);
   localparam logic [LAT_W-1:0]  c_lat_reload = LAT_W'(READ_LAT - 1);

   state_t             r_state;
   logic [LAT_W-1:0]   r_lat_cnt;
   logic               r_abort_pend;

   state_t             w_state_nxt;
   logic [LAT_W-1:0]   w_lat_nxt;
   logic               w_pend_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic               w_valid_nxt;
   logic [DATA_W-1:0]  w_data_nxt;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic               w_last_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_lat_cnt    <= '0;
         r_abort_pend <= 1'b0;
         reg_sel      <= '0;
         dout_valid   <= 1'b0;
         dout_data    <= '0;
         dout_idx     <= '0;
         dout_last    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_lat_cnt    <= w_lat_nxt;
         r_abort_pend <= w_pend_nxt;
         reg_sel      <= w_sel_nxt;
         dout_valid   <= w_valid_nxt;
         dout_data    <= w_data_nxt;
         dout_idx     <= w_idx_nxt;
         dout_last    <= w_last_nxt;
         busy         <= w_busy_nxt;
         done         <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lat_nxt   = r_lat_cnt;
      w_pend_nxt  = r_abort_pend;
      w_sel_nxt   = reg_sel;
      w_valid_nxt = dout_valid;
      w_data_nxt  = dout_data;
      w_idx_nxt   = dout_idx;
      w_last_nxt  = dout_last;
      w_busy_nxt  = busy;
      w_done_nxt  = done;

      case (r_state)
         ST_IDLE: begin
            w_pend_nxt = 1'b0;
            if (abort) begin
               w_busy_nxt = 1'b0;
            end else if (start) begin
               w_sel_nxt   = c_first;
               w_busy_nxt  = 1'b1;
               w_lat_nxt   = c_lat_reload;
               w_state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (abort) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (r_lat_cnt == '0) begin
               w_data_nxt  = reg_data;
               w_idx_nxt   = reg_sel;
               w_last_nxt  = (reg_sel == c_last);
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end else begin
               w_lat_nxt = r_lat_cnt - LAT_W'(1);
            end
         end

         ST_SEND: begin
            // An abort here is remembered so the offered beat is never withdrawn.
            w_pend_nxt = r_abort_pend | abort;
            if (dout_ready) begin
               w_valid_nxt = 1'b0;
               if (r_abort_pend || abort) begin
                  w_pend_nxt  = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end else if (dout_last) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  if (reg_sel < c_last) begin
                     w_sel_nxt = reg_sel + SEL_W'(1);
                  end
                  w_lat_nxt   = c_lat_reload;
                  w_state_nxt = ST_WAIT;
               end
            end
         end

         ST_DONE: begin
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire
